// File: rtl/equal_precision_counter_pkg.sv
// Shared definitions for the equal-precision frequency counter:
// measurement FSM states and default gate / timeout lengths.
package equal_precision_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_GATE_CYCLES    = 100000;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/equal_precision_counter_signal_edge_sync.sv
// Brings the asynchronous signal under test into the sample-clock domain and
// produces a one-cycle pulse on each synchronized 0->1 transition. Pulses are
// suppressed until all three history flops hold real samples after reset, so a
// signal already high at reset release does not look like an edge.
module signal_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic       sig_p0;
  logic       sig_p1;
  logic       sig_p2;
  logic [1:0] warm;

  // Two-flop synchronizer followed by the previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_p0 <= 1'b0;
      sig_p1 <= 1'b0;
      sig_p2 <= 1'b0;
    end else begin
      sig_p0 <= din;
      sig_p1 <= sig_p0;
      sig_p2 <= sig_p1;
    end
  end

  // Count filled history stages; edges are trusted once all three are valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm <= 2'd0;
    end else if (warm != 2'd3) begin
      warm <= warm + 2'd1;
    end
  end

  assign rise = (warm == 2'd3) && sig_p1 && !sig_p2;

endmodule

// File: rtl/equal_precision_counter.sv
// Equal-precision (reciprocal) frequency counter. After Start, the gate opens
// on a signal edge and closes on the first signal edge once the reference count
// reaches GATE_CYCLES, so both counts cover a whole number of signal periods.
module equal_precision_counter
  import equal_precision_counter_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int GATE_CYCLES    = DEF_GATE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             HighSpeedClock,
  input  logic             nReset,
  input  logic             SignalIn,
  input  logic             Start,
  output logic             Busy,
  output logic [CNT_W-1:0] SigCount,
  output logic [CNT_W-1:0] RefCount,
  output logic             ResultValid,
  input  logic             ResultReady,
  output logic             Overflow,
  output logic             Timeout
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [63:0]      GATE_LIM = 64'(GATE_CYCLES);
  localparam logic [63:0]      TMO_LIM  = 64'(TIMEOUT_CYCLES);

  state_t           state, state_n;
  logic [CNT_W-1:0] ref_q, ref_n;
  logic [CNT_W-1:0] sig_q, sig_n;
  logic             ovf_q, ovf_n;
  logic             tmo_q, tmo_n;
  logic [TMO_W-1:0] wait_q, wait_n;
  logic             sig_edge;
  logic             gate_full;
  logic             wait_done;
  logic             ref_sat;
  logic             sig_sat;

  signal_edge_sync u_sync (
    .clk   (HighSpeedClock),
    .rst_n (nReset),
    .din   (SignalIn),
    .rise  (sig_edge)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign ref_sat   = (ref_q == CNT_MAX);
  assign sig_sat   = (sig_q == CNT_MAX);
  assign gate_full = (64'(ref_q) + 64'd1) >= GATE_LIM;
  assign wait_done = (64'(wait_q) + 64'd1) >= TMO_LIM;

  // Next-state and next-count logic for the measurement sequence
  always_comb begin
    state_n = state;
    ref_n   = ref_q;
    sig_n   = sig_q;
    ovf_n   = ovf_q;
    tmo_n   = tmo_q;
    wait_n  = wait_q;
    case (state)
      IDLE: begin
        wait_n = '0;
        if (Start) begin
          state_n = ARM;
          ref_n   = '0;
          sig_n   = '0;
          ovf_n   = 1'b0;
          tmo_n   = 1'b0;
        end
      end
      ARM: begin
        if (sig_edge) begin
          // Opening edge itself is not counted; both counts start from zero
          state_n = GATE;
          ref_n   = '0;
          sig_n   = '0;
        end else if (wait_done) begin
          state_n = DONE;
          tmo_n   = 1'b1;
          ref_n   = '0;
          sig_n   = '0;
        end else begin
          wait_n = wait_q + TMO_W'(1);
        end
      end
      GATE: begin
        ref_n = sat_inc(ref_q);
        if (ref_sat) ovf_n = 1'b1;
        if (sig_edge) begin
          sig_n = sat_inc(sig_q);
          if (sig_sat) ovf_n = 1'b1;
          // A saturated counter forces the gate shut on the next available edge
          if (gate_full || ovf_q || ref_sat || sig_sat) state_n = DONE;
        end
      end
      DONE: begin
        if (ResultReady) begin
          wait_n = '0;
          if (Start) begin
            state_n = ARM;
            ref_n   = '0;
            sig_n   = '0;
            ovf_n   = 1'b0;
            tmo_n   = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and counter registers; reset discards any measurement in progress
  always_ff @(posedge HighSpeedClock or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      ref_q  <= '0;
      sig_q  <= '0;
      ovf_q  <= 1'b0;
      tmo_q  <= 1'b0;
      wait_q <= '0;
    end else begin
      state  <= state_n;
      ref_q  <= ref_n;
      sig_q  <= sig_n;
      ovf_q  <= ovf_n;
      tmo_q  <= tmo_n;
      wait_q <= wait_n;
    end
  end

  assign Busy        = (state == ARM) || (state == GATE);
  assign ResultValid = (state == DONE);
  assign SigCount    = sig_q;
  assign RefCount    = ref_q;
  assign Overflow    = ovf_q;
  assign Timeout     = tmo_q;

endmodule

// File: doc/equal_precision_counter.md
EQUAL_PRECISION_COUNTER -- requirements
Module: equal_precision_counter

Interface
REQ-001 Parameter: CNT_W, 32, width of both result counters.
REQ-002 Parameter: GATE_CYCLES, 100000, minimum gate length in HighSpeedClock cycles.
REQ-003 Parameter: TIMEOUT_CYCLES, 1000000, maximum wait for the opening edge.
REQ-004 Port: HighSpeedClock  in  1  sole clock (5.6 GHz multiphase-derived sample clock); all state on its rising edge.
REQ-005 Port: nReset  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: SignalIn  in  1  signal under test, asynchronous to HighSpeedClock.
REQ-007 Port: Start  in  1  single-cycle request for one measurement.
REQ-008 Port: Busy  out  1  high while not in IDLE or DONE.
REQ-009 Port: SigCount  out  CNT_W  rising edges of SignalIn inside the gate.
REQ-010 Port: RefCount  out  CNT_W  HighSpeedClock cycles inside the gate.
REQ-011 Port: ResultValid  out  1  result available.
REQ-012 Port: ResultReady  in  1  consumer accepts result.
REQ-013 Port: Overflow  out  1  a counter saturated.
REQ-014 Port: Timeout  out  1  no opening edge within TIMEOUT_CYCLES.

Function
REQ-015 SignalIn SHALL pass a 2-flop synchronizer plus 1 edge-detect flop; an "edge" is a detected 0->1 of the synchronized signal (3-cycle latency).
REQ-016 FSM states SHALL be IDLE, ARM, GATE, DONE.
REQ-017 IDLE: Start -> ARM next cycle; timeout counter cleared.
REQ-018 ARM: edge -> GATE, RefCount and SigCount cleared to 0; timeout counter reaching TIMEOUT_CYCLES -> DONE with Timeout=1, counts 0.
REQ-019 GATE: RefCount increments every cycle; SigCount increments on each edge.
REQ-020 Gate closes on the first edge for which RefCount+1 >= GATE_CYCLES; that cycle latches RefCount+1 and SigCount+1, then -> DONE.
REQ-021 Counters SHALL saturate at all-ones, set Overflow, and the gate SHALL close on the next edge.
REQ-022 DONE: ResultValid=1, outputs stable until ResultValid&&ResultReady; then -> IDLE.
REQ-023 Start in DONE on the same cycle as the handshake SHALL go directly to ARM; Start in DONE without handshake, or in ARM/GATE, SHALL be ignored.
REQ-024 Overflow and Timeout SHALL be cleared on entering ARM.

Reset
REQ-025 nReset low SHALL force IDLE, all outputs 0, synchronizer flops 0, at any time including mid-gate; no partial result is emitted.
REQ-026 After nReset release, the first edge detection SHALL require three clock cycles of valid SignalIn history.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and the default GATE_CYCLES/TIMEOUT_CYCLES constants.
REQ-028 The synchronizer+edge detector SHALL be one sub-module, signal_edge_sync.
REQ-029 Implementation SHALL be synchronous single-clock logic; no gating of HighSpeedClock.

Verification
REQ-030 GATE_CYCLES=100, SignalIn period 10 cycles, Start -> SigCount=10, RefCount=100, ResultValid=1, flags 0.
REQ-031 GATE_CYCLES=100, period 30 cycles -> SigCount=4, RefCount=120.
REQ-032 SignalIn held 0, TIMEOUT_CYCLES=50, Start -> ResultValid after 50 ARM cycles, Timeout=1, counts 0.
REQ-033 CNT_W=4, GATE_CYCLES=100, period 2 -> RefCount=15 saturated, Overflow=1, result on next edge.
REQ-034 ResultReady held 0 for 20 cycles in DONE -> outputs unchanged; Start with ResultReady=1 -> ARM next cycle.
REQ-035 nReset pulsed low mid-GATE -> immediate IDLE, all outputs 0, no ResultValid.
